t04_fetch: RTL and testbench

Instruction fetch unit that produces the 32-bit instruction word consumed by the team_04 decode stage.
- Owns the program counter and issues word reads to program memory over a request/acknowledge handshake.
- Holds each fetched instruction stable until the pipeline releases it.
- Applies branch/jump redirects from the control unit, including redirects that arrive while a memory read is outstanding.

---
 rtl/t04_pkg.sv | 14 +
 rtl/t04_fetch.sv | 99 +++++++++
 tb/tb_t04_fetch.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/t04_pkg.sv
// Shared team_04 definitions: fetch FSM states and the reset/NOP constants
// used by fetch, decode and control.
package t04_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

endpackage

// File: rtl/t04_fetch.sv
// Instruction fetch: owns the PC, reads program memory over mem_read/mem_ack
// and presents one instruction at a time to decode, honouring redirects.
module t04_fetch
  import t04_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic        misaligned
);

  // Handshake: mem_read stays high with mem_addr frozen until the cycle
  // mem_ack is seen; that single ack cycle completes the transfer.
  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pend_pc;
  logic         kill;
  logic [31:0]  redirect_pc;

  assign redirect_pc = {branch_target[31:2], 2'b00};
  assign mem_read    = (state == FETCH);
  assign mem_addr    = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pend_pc     <= RESET_PC;
      kill        <= 1'b0;
      instruction <= NOP_INSTR;
      instr_valid <= 1'b0;
      pc_out      <= RESET_PC;
      misaligned  <= 1'b0;
    end else begin
      if (branch_taken && (branch_target[1:0] != 2'b00))
        misaligned <= 1'b1;

      case (state)
        IDLE: begin
          if (branch_taken)
            pc <= redirect_pc;
          if (en)
            state <= FETCH;
        end

        FETCH: begin
          if (mem_ack) begin
            if (branch_taken) begin
              pc   <= redirect_pc;
              kill <= 1'b0;
            end else if (kill) begin
              // The outstanding read finished; only now may the address move.
              pc   <= pend_pc;
              kill <= 1'b0;
            end else begin
              instruction <= mem_rdata;
              pc_out      <= pc;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end else if (branch_taken) begin
            kill    <= 1'b1;
            pend_pc <= redirect_pc;
          end
        end

        HOLD: begin
          if (branch_taken) begin
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
            instruction <= NOP_INSTR;
            state       <= FETCH;
          end else if (!stall) begin
            pc          <= pc + 32'd4;
            instr_valid <= 1'b0;
            instruction <= NOP_INSTR;
            state       <= en ? FETCH : IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t04_fetch.sv
// Directed bench for t04_fetch: a scripted memory responder pushes each word
// that must reach decode, and a monitor pops it when instr_valid rises.
module tb_t04_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        en;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic        misaligned;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];  // {pc, instruction}
  logic        prev_valid = 1'b0;

  t04_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_read      (mem_read),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc_out        (pc_out),
    .misaligned    (misaligned)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rising instr_valid must match the oldest expected word.
  always @(negedge clk) begin
    if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_present", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("sb_instruction", instruction, e[31:0]);
        check("sb_pc_out", pc_out, e[63:32]);
      end
    end
    prev_valid = instr_valid;
  end

  // Serve one read at addr after 'waits' idle cycles; present says whether
  // the word is expected to reach decode.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input int waits, input bit present);
    mem_ack = 1'b0;
    for (int i = 0; i < waits; i++) begin
      check({tag, "_wait_read"}, {31'b0, mem_read}, 32'd1);
      check({tag, "_wait_addr"}, mem_addr, addr);
      tick();
    end
    check({tag, "_read"}, {31'b0, mem_read}, 32'd1);
    check({tag, "_addr"}, mem_addr, addr);
    mem_ack   = 1'b1;
    mem_rdata = data;
    if (present) exp_q.push_back({addr, data});
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check({tag, "_valid"}, {31'b0, instr_valid}, {31'b0, present});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_target = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_read", {31'b0, mem_read}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instruction, NOP);
    check("rst_pc_out", pc_out, 32'd0);
    check("rst_misaligned", {31'b0, misaligned}, 32'd0);

    // First fetch, immediate ack
    en = 1'b1;
    tick();
    do_fetch("f0", 32'h0, 32'h0050_0093, 0, 1);
    check("f0_instr", instruction, 32'h0050_0093);
    check("f0_pc_out", pc_out, 32'h0);
    tick();
    check("f1_addr", mem_addr, 32'h4);

    // Stall in HOLD for 5 cycles
    stall = 1'b1;
    do_fetch("f1", 32'h4, 32'h0010_8113, 0, 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_instr", instruction, 32'h0010_8113);
      check("stall_pc_out", pc_out, 32'h4);
      check("stall_read", {31'b0, mem_read}, 32'd0);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      tick();
    end
    stall = 1'b0;
    tick();
    check("post_stall_addr", mem_addr, 32'h8);

    // Ack delayed 3 cycles
    do_fetch("slow", 32'h8, 32'h0020_8193, 3, 1);
    tick();
    check("slow_released", {31'b0, instr_valid}, 32'd0);
    check("next_addr_c", mem_addr, 32'hC);

    // Redirect while FETCH waits for ack
    branch_target = 32'h40; branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    do_fetch("killed", 32'hC, 32'hDEAD_BEEF, 1, 0);
    check("kill_redirect_addr", mem_addr, 32'h40);
    check("kill_read", {31'b0, mem_read}, 32'd1);
    stall = 1'b1;
    do_fetch("target40", 32'h40, 32'h0030_8213, 0, 1);
    tick();
    check("hold40_valid", {31'b0, instr_valid}, 32'd1);
    check("hold40_read", {31'b0, mem_read}, 32'd0);

    // Misaligned redirect in HOLD with stall held
    branch_target = 32'h102; branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    check("hbr_valid", {31'b0, instr_valid}, 32'd0);
    check("hbr_instr", instruction, NOP);
    check("hbr_misaligned", {31'b0, misaligned}, 32'd1);
    check("hbr_read", {31'b0, mem_read}, 32'd1);
    check("hbr_addr", mem_addr, 32'h100);
    stall = 1'b0;
    tick();
    check("hbr_addr_stable", mem_addr, 32'h100);
    check("misaligned_sticky", {31'b0, misaligned}, 32'd1);

    // Redirect coinciding with ack, to the top word, then wrap
    branch_target = 32'hFFFF_FFFC; branch_taken = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    branch_taken = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    check("ackbr_valid", {31'b0, instr_valid}, 32'd0);
    check("ackbr_addr", mem_addr, 32'hFFFF_FFFC);
    do_fetch("top", 32'hFFFF_FFFC, 32'h0040_8293, 0, 1);
    tick();
    check("wrap_addr", mem_addr, 32'h0);
    check("wrap_misaligned", {31'b0, misaligned}, 32'd1);

    // en dropped during FETCH: completes, HOLD, then IDLE
    en = 1'b0;
    do_fetch("endrop", 32'h0, 32'h0050_8313, 1, 1);
    tick();
    check("idle_read", {31'b0, mem_read}, 32'd0);
    check("idle_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    check("idle_read2", {31'b0, mem_read}, 32'd0);

    // Redirect in IDLE loads pc directly
    branch_target = 32'h200; branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0; en = 1'b1;
    check("idlebr_read", {31'b0, mem_read}, 32'd0);
    tick();
    do_fetch("t200", 32'h200, 32'h0060_8393, 0, 1);
    tick();
    check("addr_204", mem_addr, 32'h204);

    // Reset mid-FETCH
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    check("mrst_read", {31'b0, mem_read}, 32'd0);
    check("mrst_addr", mem_addr, 32'h0);
    check("mrst_valid", {31'b0, instr_valid}, 32'd0);
    check("mrst_instr", instruction, NOP);
    check("mrst_pc_out", pc_out, 32'h0);
    check("mrst_misaligned", {31'b0, misaligned}, 32'd0);
    tick();

    check("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
